// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit owning HI/LO; 32-cycle shift-add / restoring divide.
// Optional EX_MULDIV_FAST_MUL_EN: single-cycle combinational multiply, divide stays iterative.
module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W   = {{(2*DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                div_q, div_d;
    logic                dz_q, dz_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   rs_q, rs_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                busy_q;

    logic                signed_op_s, rs_neg_s, rt_neg_s;
    logic [DATA_W-1:0]   rs_abs_s, rt_abs_s;
    logic [DATA_W:0]     mul_sum_s, rem_sh_s, diff_s;
    logic [2*DATA_W-1:0] mul_next_s, div_next_s, prod_s;
    logic [DATA_W-1:0]   quot_s, rem_s;

    assign signed_op_s = ~op[0];
    assign rs_neg_s    = signed_op_s & rs[DATA_W-1];
    assign rt_neg_s    = signed_op_s & rt[DATA_W-1];
    assign rs_abs_s    = rs_neg_s ? (~rs + ONE_W) : rs;
    assign rt_abs_s    = rt_neg_s ? (~rt + ONE_W) : rt;

    // Multiply step: conditionally add multiplicand to upper half, then shift right.
    assign mul_sum_s  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                      + (acc_q[0] ? {1'b0, b_q} : {(DATA_W+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_q[DATA_W-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign rem_sh_s   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign diff_s     = rem_sh_s - {1'b0, b_q};
    assign div_next_s = diff_s[DATA_W] ? {rem_sh_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                       : {diff_s[DATA_W-1:0],   acc_q[DATA_W-2:0], 1'b1};

    assign prod_s = neg_q     ? (~acc_q + ONE_2W) : acc_q;
    assign quot_s = neg_q     ? (~acc_q[DATA_W-1:0] + ONE_W) : acc_q[DATA_W-1:0];
    assign rem_s  = rem_neg_q ? (~acc_q[2*DATA_W-1:DATA_W] + ONE_W) : acc_q[2*DATA_W-1:DATA_W];

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        dz_d      = dz_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        b_d       = b_q;
        rs_d      = rs_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            div_d     = op[1];
                            dz_d      = op[1] & (rt == ZERO_W);
                            neg_d     = rs_neg_s ^ rt_neg_s;
                            rem_neg_d = rs_neg_s;
                            rs_d      = rs;
                            cnt_d     = {CNT_W{1'b0}};
                            if (op[1]) begin
                                b_d     = rt_abs_s;
                                acc_d   = {ZERO_W, rs_abs_s};
                                state_d = S_RUN;
                            end else begin
                                b_d     = rs_abs_s;
`ifdef EX_MULDIV_FAST_MUL_EN
                                acc_d   = {ZERO_W, rs_abs_s} * {ZERO_W, rt_abs_s};
                                state_d = S_FIX;
`else
                                acc_d   = {ZERO_W, rt_abs_s};
                                state_d = S_RUN;
`endif
                            end
                        end
                        3'd4:    hi_d = rs;
                        3'd5:    lo_d = rs;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? div_next_s : mul_next_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIX: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (!div_q) begin
                        hi_d = prod_s[2*DATA_W-1:DATA_W];
                        lo_d = prod_s[DATA_W-1:0];
                    end else if (dz_q) begin
                        hi_d = rs_q;
                        lo_d = {DATA_W{1'b1}};
                    end else begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_q       <= ZERO_W;
            rs_q      <= ZERO_W;
            acc_q     <= {(2*DATA_W){1'b0}};
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            dz_q      <= dz_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            b_q       <= b_d;
            rs_q      <= rs_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (honours EX_MULDIV_FAST_MUL_EN for multiply latency).
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one start pulse; returns 1 ns after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count busy cycles until busy falls (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_op(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(o, a, b);
        wait_idle(n);
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL %s latency: busy cycles=%0d, required %0d", name, n, lat);
        end
        checks++;
        if (done !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL %s result: done=%b hi=%h lo=%h, required done=1 hi=%h lo=%h",
                     name, done, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mul;
        test_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
        test_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000005, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1);
    endtask

    task automatic test_div;
        test_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h00000002, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_op("divu_zero", 3'd3, 32'h00000007, 32'h00000000, DIV_LAT, 32'h00000007, 32'hFFFFFFFF);
        test_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h00000000, 32'h80000000);
        test_op("div_zero_signed", 3'd2, 32'hFFFFFFF9, 32'h00000000, DIV_LAT, 32'hFFFFFFF9, 32'hFFFFFFFF);
    endtask

    task automatic test_back_to_back;
        // Issued directly from the done cycle.
        test_op("divu_first", 3'd3, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
        test_op("multu_b2b", 3'd1, 32'd6, 32'd7, MUL_LAT, 32'd0, 32'd42);
    endtask

    task automatic test_mthi_mtlo;
        issue(3'd4, 32'h12345678, 32'h0);
        checks++;
        if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b done=%b, required 12345678/0/0", hi, busy, done);
        end
        issue(3'd5, 32'h9ABCDEF0, 32'h0);
        checks++;
        if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, required 12345678/9abcdef0/0/0",
                     hi, lo, busy, done);
        end
        issue(3'd6, 32'hDEADBEEF, 32'h1);
        checks++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL noop: hi=%h lo=%h busy=%b, required 12345678/9abcdef0/0", hi, lo, busy);
        end
        cancel = 1'b1;
        issue(3'd4, 32'hCAFEF00D, 32'h0);
        cancel = 1'b0;
        checks++;
        if (hi !== 32'h12345678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start_idle: hi=%h busy=%b, required 12345678/0", hi, busy);
        end
    endtask

    task automatic test_cancel;
        int seen_done;
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL cancel: busy=%b done=%b hi=%h lo=%h, required 0/0/12345678/9abcdef0",
                     busy, done, hi, lo);
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            errors++;
            $display("FAIL cancel_after: done pulses=%0d hi=%h lo=%h, required 0/12345678/9abcdef0",
                     seen_done, hi, lo);
        end
    endtask

    task automatic test_start_while_busy;
        int n;
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        issue(3'd1, 32'd5, 32'd5);
        wait_idle(n);
        checks++;
        if (4 + n !== DIV_LAT || done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL start_busy: cycles=%0d done=%b hi=%h lo=%h, required %0d/1/2/14",
                     4 + n, done, hi, lo, DIV_LAT);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_idle: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        issue(3'd3, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        rs     = 32'h0;
        rt     = 32'h0;
        cancel = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_back_to_back();
        test_mthi_mtlo();
        test_cancel();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
